// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: generates the PC stream, fetches from
// instruction memory over a req/gnt/rvalid handshake (one request in flight)
// and holds one fetched instruction for the IF/ID register.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush, jmp_addr        redirect (priority over stall) and its target
//   stall                  downstream is not accepting this cycle
//   imem_req/addr          fetch request and word-aligned address
//   imem_gnt               request accepted this cycle
//   imem_rvalid/rdata      read response
//   pc_o, inst_o           buffered PC and instruction (NOP when empty)
//   inst_valid_o           buffer holds a real fetched instruction
module ifu_fetch #(
  parameter int unsigned           ADDR_LEN = 32,
  parameter int unsigned           ISA_LEN  = 32,
  parameter logic [ADDR_LEN-1:0]   RESET_PC = 32'h0000_0000,
  parameter logic [ISA_LEN-1:0]    NOP_INST = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [ADDR_LEN-1:0] jmp_addr,
  input  logic                stall,
  output logic                imem_req,
  output logic [ADDR_LEN-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [ISA_LEN-1:0]  imem_rdata,
  output logic [ADDR_LEN-1:0] pc_o,
  output logic [ISA_LEN-1:0]  inst_o,
  output logic                inst_valid_o
);

  localparam logic [ADDR_LEN-1:0] WORD_MASK = ~ADDR_LEN'(3);
  localparam logic [ADDR_LEN-1:0] PC_STEP   = ADDR_LEN'(4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_LEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ISA_LEN-1:0]    buf_inst_q, buf_inst_d;
  logic [ADDR_LEN-1:0]   buf_pc_q, buf_pc_d;
  logic                  buf_valid_q, buf_valid_d;
  logic                  imem_req_c;

  // State and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      buf_inst_q  <= NOP_INST;
      buf_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // Next-state, buffer update and request generation
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    imem_req_c  = 1'b0;

    // Consumption; a same-cycle reload in WAIT overrides this below.
    if (buf_valid_q && !stall) begin
      buf_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // Only request when the response has somewhere to land.
        imem_req_c = !buf_valid_q || !stall;
        if (imem_req_c && imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          buf_inst_d  = imem_rdata;
          buf_pc_d    = fetch_pc_q;
          buf_valid_d = 1'b1;
          fetch_pc_d  = fetch_pc_q + PC_STEP;
          state_d     = REQ;
        end
      end
      DROP: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; an in-flight request must be drained.
    if (flush) begin
      fetch_pc_d  = jmp_addr & WORD_MASK;
      buf_inst_d  = buf_inst_q;
      buf_pc_d    = buf_pc_q;
      buf_valid_d = 1'b0;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = (imem_req_c && imem_gnt) ? DROP : REQ;
        WAIT:    state_d = imem_rvalid ? REQ : DROP;
        // The stale response arriving this cycle ends the drain.
        DROP:    state_d = imem_rvalid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem_req     = imem_req_c;
  assign imem_addr    = fetch_pc_q & WORD_MASK;
  assign pc_o         = buf_pc_q;
  assign inst_valid_o = buf_valid_q;
  assign inst_o       = buf_valid_q ? buf_inst_q : NOP_INST;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small single-outstanding memory
// responder whose grant and response latency are set by the test sequence.
module tb_ifu_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] jmp_addr;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .jmp_addr     (jmp_addr),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o)
  );

  // Memory responder: data is derived from the requested address.
  logic        auto_gnt;
  logic [1:0]  lat;
  logic        pend_q;
  logic [1:0]  cnt_q;
  logic [31:0] raddr_q;

  always_comb imem_gnt = auto_gnt & imem_req;
  assign imem_rvalid = pend_q && (cnt_q == 2'd1);
  assign imem_rdata  = imem_rvalid ? {16'hC0DE, raddr_q[15:0]} : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      cnt_q   <= 2'd0;
      raddr_q <= 32'h0;
    end else begin
      if (pend_q && cnt_q == 2'd1) pend_q <= 1'b0;
      else if (pend_q)             cnt_q  <= cnt_q - 2'd1;
      if (imem_req && imem_gnt) begin
        pend_q  <= 1'b1;
        cnt_q   <= lat;
        raddr_q <= imem_addr;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; jmp_addr = 32'h0; stall = 1'b0;
    auto_gnt = 1'b1; lat = 2'd1;
    #3;
    check("rst_req",   32'(imem_req), 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'h0);
    check("rst_inst",  inst_o, NOP);
    check("rst_pc",    pc_o, 32'h0);
    #9 rst_n = 1'b1;

    // 1: zero-wait streaming
    tick();
    check("t1_req0",  32'(imem_req), 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    tick();
    check("t1_wait_req", 32'(imem_req), 32'h0);
    tick();
    check("t1_v0",    32'(inst_valid_o), 32'h1);
    check("t1_inst0", inst_o, 32'hC0DE_0000);
    check("t1_pc0",   pc_o, 32'h0);
    check("t1_addr4", imem_addr, 32'h4);
    check("t1_req4",  32'(imem_req), 32'h1);
    tick();
    check("t1_nop",   inst_o, NOP);
    tick();
    check("t1_inst4", inst_o, 32'hC0DE_0004);
    check("t1_pc4",   pc_o, 32'h4);
    check("t1_addr8", imem_addr, 32'h8);

    // 2: stall holds a full buffer and blocks requests
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t2_req",  32'(imem_req), 32'h0);
      check("t2_pc",   pc_o, 32'h4);
      check("t2_inst", inst_o, 32'hC0DE_0004);
      tick();
    end
    stall = 1'b0;
    lat = 2'd3;
    #1;
    check("t2_req_resume", 32'(imem_req), 32'h1);
    check("t2_addr8",      imem_addr, 32'h8);
    tick();

    // 3: flush while waiting on 0x8, response 3 cycles later
    check("t3_wait_novalid", 32'(inst_valid_o), 32'h0);
    flush = 1'b1; jmp_addr = 32'h100;
    tick();
    flush = 1'b0; lat = 2'd1;
    check("t3_drop_req", 32'(imem_req), 32'h0);
    check("t3_v_a",      32'(inst_valid_o), 32'h0);
    tick();
    check("t3_rvalid",   32'(imem_rvalid), 32'h1);
    check("t3_v_b",      32'(inst_valid_o), 32'h0);
    tick();
    check("t3_v_c",      32'(inst_valid_o), 32'h0);
    check("t3_req",      32'(imem_req), 32'h1);
    check("t3_addr",     imem_addr, 32'h100);
    tick();
    tick();
    check("t3_inst", inst_o, 32'hC0DE_0100);
    check("t3_pc",   pc_o, 32'h100);

    // 4: flush in REQ without grant redirects the pending request
    auto_gnt = 1'b0;
    flush = 1'b1; jmp_addr = 32'h203;
    tick();
    flush = 1'b0;
    check("t4_req",  32'(imem_req), 32'h1);
    check("t4_addr", imem_addr, 32'h200);
    check("t4_v",    32'(inst_valid_o), 32'h0);
    auto_gnt = 1'b1;
    tick();

    // 5: flush together with rvalid in WAIT
    check("t5_rvalid", 32'(imem_rvalid), 32'h1);
    flush = 1'b1; jmp_addr = 32'h40;
    tick();
    flush = 1'b0;
    check("t5_v",    32'(inst_valid_o), 32'h0);
    check("t5_inst", inst_o, NOP);
    check("t5_req",  32'(imem_req), 32'h1);
    check("t5_addr", imem_addr, 32'h40);
    tick();
    tick();
    check("t5_pc",   pc_o, 32'h40);
    check("t5_inst40", inst_o, 32'hC0DE_0040);
    tick();

    // 6: async reset mid-WAIT, then PC wrap
    #1 rst_n = 1'b0;
    #1;
    check("t6_req",   32'(imem_req), 32'h0);
    check("t6_v",     32'(inst_valid_o), 32'h0);
    check("t6_inst",  inst_o, NOP);
    check("t6_pc",    pc_o, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    check("t6_req_rel",  32'(imem_req), 32'h1);
    check("t6_addr_rel", imem_addr, 32'h0);
    auto_gnt = 1'b0;
    flush = 1'b1; jmp_addr = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0; auto_gnt = 1'b1;
    check("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("t6_pc_top",   pc_o, 32'hFFFF_FFFC);
    check("t6_inst_top", inst_o, 32'hC0DE_FFFC);
    check("t6_wrap",     imem_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
